// File: rtl/irq_ctrl.sv
// ----------------------------------------------------------------------------
// irq_ctrl : masks/latches NUM_SRC device interrupts, fixed priority to CPU
//            with a claim / end-of-interrupt handshake over the device bus.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module irq_ctrl #(
  parameter int NUM_SRC = 6,
  parameter int ID_W    = 3
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  input  logic               STB_I,
  input  logic               WE_I,
  input  logic [1:0]         ADD_I,
  input  logic [31:0]        DAT_I,
  output logic [31:0]        DAT_O,
  input  logic [NUM_SRC-1:0] SRC_I,
  output logic               IRQ,
  output logic [ID_W-1:0]    IRQ_ID
);

  localparam logic [1:0] c_ADDR_MASK  = 2'd0;
  localparam logic [1:0] c_ADDR_PEND  = 2'd1;
  localparam logic [1:0] c_ADDR_EDGE  = 2'd2;
  localparam logic [1:0] c_ADDR_CLAIM = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t             r_state;
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_edge_sel;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_src_d;
  logic [ID_W-1:0]    r_served_id;
  logic               r_irq;
  logic [ID_W-1:0]    r_irq_id;

  logic [NUM_SRC-1:0] w_active;
  logic               w_any_active;
  logic [ID_W-1:0]    w_winner;
  logic               w_wr;
  logic               w_wr_mask;
  logic               w_wr_pend;
  logic               w_wr_edge;
  logic               w_claim;
  logic               w_eoi;
  logic [NUM_SRC-1:0] w_wdata;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_es_chg;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_pending_nxt;
  logic               w_unused_dat;

  assign w_wdata      = DAT_I[NUM_SRC-1:0];
  assign w_unused_dat = &{1'b0, DAT_I};

  assign w_active     = r_pending & r_mask;
  assign w_any_active = |w_active;

  // Scan high-to-low so the lowest set index is the one left standing.
  always_comb begin
    w_winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_active[i]) w_winner = ID_W'(i);
    end
  end

  assign w_wr      = STB_I & WE_I;
  assign w_wr_mask = w_wr & (ADD_I == c_ADDR_MASK);
  assign w_wr_pend = w_wr & (ADD_I == c_ADDR_PEND);
  assign w_wr_edge = w_wr & (ADD_I == c_ADDR_EDGE);
  assign w_claim   = STB_I & ~WE_I & (ADD_I == c_ADDR_CLAIM)
                   & (r_state == S_ACTIVE) & w_any_active;
  assign w_eoi     = w_wr & (ADD_I == c_ADDR_CLAIM) & (r_state == S_SERVICE)
                   & (DAT_I[ID_W-1:0] == r_served_id);

  assign w_rise   = SRC_I & ~r_src_d;
  assign w_es_chg = w_wr_edge ? (w_wdata ^ r_edge_sel) : '0;
  assign w_clr    = (w_wr_pend ? w_wdata : '0)
                  | (w_claim ? (NUM_SRC'(1) << w_winner) : '0);

  // A new rising edge outranks any clear landing on the same clock.
  always_comb begin
    w_pending_nxt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_es_chg[i])
        w_pending_nxt[i] = 1'b0;
      else if (!r_edge_sel[i])
        w_pending_nxt[i] = SRC_I[i];
      else
        w_pending_nxt[i] = w_rise[i] | (r_pending[i] & ~w_clr[i]);
    end
  end

  always_comb begin
    DAT_O = '0;
    case (ADD_I)
      c_ADDR_MASK:  DAT_O = {{(32-NUM_SRC){1'b0}}, r_mask};
      c_ADDR_PEND:  DAT_O = {{(32-NUM_SRC){1'b0}}, r_pending};
      c_ADDR_EDGE:  DAT_O = {{(32-NUM_SRC){1'b0}}, r_edge_sel};
      c_ADDR_CLAIM: begin
        if ((r_state == S_ACTIVE) && w_any_active)
          DAT_O = {1'b1, {(31-ID_W){1'b0}}, w_winner};
      end
      default:      DAT_O = '0;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_mask     <= '0;
      r_edge_sel <= '0;
      r_pending  <= '0;
      r_src_d    <= '0;
    end else begin
      r_src_d   <= SRC_I;
      r_pending <= w_pending_nxt;
      if (w_wr_mask) r_mask     <= w_wdata;
      if (w_wr_edge) r_edge_sel <= w_wdata;
    end
  end

  // IRQ/IRQ_ID are written alongside the state so they follow next-state.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_state     <= S_IDLE;
      r_served_id <= '0;
      r_irq       <= 1'b0;
      r_irq_id    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_active) begin
            r_state  <= S_ACTIVE;
            r_irq    <= 1'b1;
            r_irq_id <= w_winner;
          end else begin
            r_irq    <= 1'b0;
            r_irq_id <= '0;
          end
        end
        S_ACTIVE: begin
          if (!w_any_active) begin
            r_state  <= S_IDLE;
            r_irq    <= 1'b0;
            r_irq_id <= '0;
          end else if (w_claim) begin
            r_state     <= S_SERVICE;
            r_served_id <= w_winner;
            r_irq       <= 1'b0;
            r_irq_id    <= '0;
          end else begin
            r_irq    <= 1'b1;
            r_irq_id <= w_winner;
          end
        end
        S_SERVICE: begin
          r_irq    <= 1'b0;
          r_irq_id <= '0;
          if (w_eoi) r_state <= S_IDLE;
        end
        default: begin
          r_state  <= S_IDLE;
          r_irq    <= 1'b0;
          r_irq_id <= '0;
        end
      endcase
    end
  end

  assign IRQ    = r_irq;
  assign IRQ_ID = r_irq_id;

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_irq_ctrl : directed self-checking bench for irq_ctrl.
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_irq_ctrl;

  localparam int NUM_SRC = 6;
  localparam int ID_W    = 3;

  logic               CLK_I = 1'b0;
  logic               RST_I = 1'b0;
  logic               STB_I = 1'b0;
  logic               WE_I  = 1'b0;
  logic [1:0]         ADD_I = 2'd0;
  logic [31:0]        DAT_I = 32'd0;
  logic [31:0]        DAT_O;
  logic [NUM_SRC-1:0] SRC_I = '0;
  logic               IRQ;
  logic [ID_W-1:0]    IRQ_ID;

  int n_checks = 0;
  int n_fails  = 0;

  irq_ctrl #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) dut (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .STB_I (STB_I),
    .WE_I  (WE_I),
    .ADD_I (ADD_I),
    .DAT_I (DAT_I),
    .DAT_O (DAT_O),
    .SRC_I (SRC_I),
    .IRQ   (IRQ),
    .IRQ_ID(IRQ_ID)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] addr, input logic [31:0] data);
    STB_I = 1'b1; WE_I = 1'b1; ADD_I = addr; DAT_I = data;
    tick();
    STB_I = 1'b0; WE_I = 1'b0; DAT_I = '0;
  endtask

  // Non-strobed peek of a register; read has no side effects.
  task automatic peek(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    STB_I = 1'b0; WE_I = 1'b0; ADD_I = addr;
    #1;
    check(tag, DAT_O, exp);
  endtask

  task automatic claim(input string tag, input logic [31:0] exp);
    STB_I = 1'b1; WE_I = 1'b0; ADD_I = 2'd3;
    #1;
    check(tag, DAT_O, exp);
    tick();
    STB_I = 1'b0;
  endtask

  task automatic do_reset();
    STB_I = 1'b0; WE_I = 1'b0; SRC_I = '0; DAT_I = '0;
    RST_I = 1'b0;
    tick();
    tick();
    RST_I = 1'b1;
  endtask

  initial begin
    // Reset values
    do_reset();
    RST_I = 1'b0;
    #1;
    check("rst_irq", {31'd0, IRQ}, 32'd0);
    check("rst_irq_id", {29'd0, IRQ_ID}, 32'd0);
    peek("rst_mask", 2'd0, 32'd0);
    peek("rst_edge", 2'd2, 32'd0);
    RST_I = 1'b1;
    tick();

    // Level source 0, claim and EOI with the line still high
    bus_wr(2'd0, 32'h01);
    SRC_I = 6'h01;
    tick();
    check("lvl_irq_k", {31'd0, IRQ}, 32'd0);
    tick();
    check("lvl_irq_k1", {31'd0, IRQ}, 32'd1);
    check("lvl_irq_id", {29'd0, IRQ_ID}, 32'd0);
    claim("lvl_claim", 32'h8000_0000);
    check("lvl_irq_after_claim", {31'd0, IRQ}, 32'd0);
    bus_wr(2'd3, 32'd0);
    check("lvl_irq_at_idle", {31'd0, IRQ}, 32'd0);
    tick();
    check("lvl_irq_reassert", {31'd0, IRQ}, 32'd1);

    // Edge sources 4 and 2 together, priority and ordering through EOI
    do_reset();
    bus_wr(2'd0, 32'h3F);
    bus_wr(2'd2, 32'h3F);
    SRC_I = 6'h14;
    tick();
    SRC_I = 6'h00;
    tick();
    check("edge_irq", {31'd0, IRQ}, 32'd1);
    check("edge_id2", {29'd0, IRQ_ID}, 32'd2);
    claim("edge_claim2", 32'h8000_0002);
    peek("edge_pend_after_claim", 2'd1, 32'h10);
    check("edge_irq_service", {31'd0, IRQ}, 32'd0);
    bus_wr(2'd3, 32'd2);
    tick();
    check("edge_irq_next", {31'd0, IRQ}, 32'd1);
    check("edge_id4", {29'd0, IRQ_ID}, 32'd4);

    // Masking an active source drops IRQ, unmasking brings it back
    do_reset();
    bus_wr(2'd0, 32'h20);
    bus_wr(2'd2, 32'h20);
    SRC_I = 6'h20;
    tick();
    tick();
    check("mask_irq_on", {31'd0, IRQ}, 32'd1);
    check("mask_id5", {29'd0, IRQ_ID}, 32'd5);
    bus_wr(2'd0, 32'h00);
    check("mask_irq_hold", {31'd0, IRQ}, 32'd1);
    tick();
    check("mask_irq_off", {31'd0, IRQ}, 32'd0);
    peek("mask_pend_kept", 2'd1, 32'h20);
    bus_wr(2'd0, 32'h20);
    tick();
    check("unmask_irq", {31'd0, IRQ}, 32'd1);
    check("unmask_id5", {29'd0, IRQ_ID}, 32'd5);
    // Asynchronous reset drops IRQ without a clock edge
    #2;
    RST_I = 1'b0;
    #1;
    check("async_rst_irq", {31'd0, IRQ}, 32'd0);
    RST_I = 1'b1;

    // Mismatched EOI ignored while in SERVICE
    do_reset();
    bus_wr(2'd0, 32'h3F);
    bus_wr(2'd2, 32'h3F);
    SRC_I = 6'h08;
    tick();
    SRC_I = 6'h00;
    tick();
    claim("svc_claim3", 32'h8000_0003);
    bus_wr(2'd3, 32'd1);
    SRC_I = 6'h01;
    tick();
    SRC_I = 6'h00;
    tick();
    check("svc_bad_eoi", {31'd0, IRQ}, 32'd0);
    peek("svc_claim_reads0", 2'd3, 32'd0);
    bus_wr(2'd3, 32'd3);
    tick();
    check("svc_good_eoi_irq", {31'd0, IRQ}, 32'd1);
    check("svc_good_eoi_id", {29'd0, IRQ_ID}, 32'd0);

    // Claim read in IDLE: returns 0, no pending clear
    do_reset();
    bus_wr(2'd2, 32'h01);
    SRC_I = 6'h01;
    tick();
    SRC_I = 6'h00;
    claim("idle_claim", 32'd0);
    peek("idle_claim_pend", 2'd1, 32'h01);
    bus_wr(2'd0, 32'h01);
    tick();
    check("idle_claim_then_irq", {31'd0, IRQ}, 32'd1);

    // W1C coinciding with a new rising edge: set wins
    do_reset();
    bus_wr(2'd2, 32'h02);
    SRC_I = 6'h02;
    tick();
    SRC_I = 6'h00;
    tick();
    peek("w1c_pre", 2'd1, 32'h02);
    SRC_I = 6'h02;
    bus_wr(2'd1, 32'h02);
    peek("w1c_set_wins", 2'd1, 32'h02);
    bus_wr(2'd1, 32'h02);
    peek("w1c_clears", 2'd1, 32'h00);

    // Level bit ignores W1C
    bus_wr(2'd2, 32'h00);
    tick();
    bus_wr(2'd1, 32'h02);
    peek("w1c_level_ignored", 2'd1, 32'h02);

    // Reset in SERVICE with pending 0x07
    do_reset();
    bus_wr(2'd0, 32'h3F);
    bus_wr(2'd2, 32'h3F);
    SRC_I = 6'h07;
    tick();
    SRC_I = 6'h00;
    tick();
    claim("rst_svc_claim", 32'h8000_0000);
    SRC_I = 6'h01;
    tick();
    SRC_I = 6'h00;
    peek("rst_svc_pend", 2'd1, 32'h07);
    #2;
    RST_I = 1'b0;
    #1;
    check("rst_svc_irq", {31'd0, IRQ}, 32'd0);
    peek("rst_svc_pend0", 2'd1, 32'h00);
    peek("rst_svc_mask0", 2'd0, 32'h00);
    peek("rst_svc_edge0", 2'd2, 32'h00);
    tick();
    RST_I = 1'b1;
    tick();
    tick();
    tick();
    check("rst_svc_quiet", {31'd0, IRQ}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Interrupt controller between the device IRQ lines (timers and other bus peripherals) and the CPU's single interrupt input. Latches and masks up to NUM_SRC sources and selects the highest-priority one. Runs an assert/claim/end-of-interrupt handshake with software over the same word-addressed device bus used by the timers. The CPU reads a claim register to learn the source ID, then writes it back to retire the interrupt.

Parameters:
NUM_SRC, 6, number of interrupt sources (1..8); source 0 has highest priority
ID_W, 3, width of a source ID field

Ports:
CLK_I  input  1  system clock, all state on rising edge
RST_I  input  1  asynchronous, active-low reset
STB_I  input  1  bus strobe; access valid this cycle
WE_I  input  1  write enable (1 = write, 0 = read) when STB_I=1
ADD_I  input  2  word address [3:2]: 0 MASK, 1 PENDING, 2 EDGE_SEL, 3 CLAIM
DAT_I  input  32  write data
DAT_O  output  32  combinational read data for ADD_I
SRC_I  input  NUM_SRC  raw interrupt request lines from devices
IRQ  output  1  registered interrupt request to CPU
IRQ_ID  output  ID_W  registered ID of the source behind IRQ (0 when IRQ=0)

Behaviour:
- Reset (RST_I=0, async): MASK=0, EDGE_SEL=0, pending=0, src_d=0, state=IDLE, served_id=0, IRQ=0, IRQ_ID=0.
- Registers: MASK[NUM_SRC-1:0] RW, 1 = enabled. EDGE_SEL[NUM_SRC-1:0] RW, 1 = rising-edge source, 0 = level source. Unused bits read 0 and ignore writes.
- PENDING: read returns pending vector. Write = write-1-to-clear, edge bits only; level bits ignore writes.
- Level source i: pending[i] <= SRC_I[i] every cycle.
- Edge source i: src_d <= SRC_I every cycle. pending[i] is set at any edge where SRC_I[i]=1 and src_d[i]=0.
- Simultaneous set and clear (W1C or claim) on the same edge: set wins.
- Changing EDGE_SEL[i] clears edge-latched pending[i] on that edge.
- active = pending & MASK. winner = lowest set index of active.
- State machine:
  - IDLE: if active != 0, go to ACTIVE.
  - ACTIVE: IRQ=1, IRQ_ID = winner, recomputed every cycle. If active becomes 0 (masked or cleared), go to IDLE and IRQ drops. A claim read goes to SERVICE.
  - SERVICE: IRQ=0. New or higher-priority requests stay pending; no nesting. An EOI write with DAT_I[ID_W-1:0]==served_id goes to IDLE. A mismatched EOI is ignored.
- Claim read: STB_I=1, WE_I=0, ADD_I=3.
  - In ACTIVE, DAT_O = {1'b1, zeros, winner}. On that edge: served_id <= winner, the winner's edge pending bit clears, state goes to SERVICE.
  - In other states, DAT_O = 0 with no side effects.
  - Non-strobed reads of any address have no side effects.
- IRQ and IRQ_ID are registered from next-state.
  - Edge source: rises at edge k+1 when SRC_I is first sampled high at edge k (pending set at k, IRQ at k+1).
  - Level source: same two-edge latency.
- IRQ falls on the edge that performs the claim.
- After EOI, a level source still high or any remaining active bit re-raises IRQ one edge after reaching IDLE.
- Writes to CLAIM outside SERVICE are ignored. Writes with STB_I=0 are ignored.
- Reset mid-operation returns everything to reset values immediately. IRQ drops asynchronously.

Test Plan:
- Reset, MASK=0x01, EDGE_SEL=0, hold SRC_I[0]=1 (timer level) -> IRQ=1, IRQ_ID=0 two edges after first sample. Claim read returns 0x80000000. IRQ=0 after that edge. EOI write 0 with SRC_I[0] still high -> IRQ re-asserts.
- MASK=0x3F, EDGE_SEL=0x3F, pulse SRC_I[4] and SRC_I[2] for one cycle each, together -> IRQ_ID=2. Claim returns 0x80000002 and PENDING reads 0x10. EOI 2 -> IRQ_ID=4.
- ACTIVE on source 5 (edge), write MASK=0x00 -> IRQ drops next edge, PENDING still 0x20. Restore MASK=0x20 -> IRQ returns.
- In SERVICE with served_id=3, write EOI 1 -> ignored, state stays SERVICE. Then EOI 3 -> IDLE. Also claim read in IDLE -> DAT_O=0, no state change.
- Edge pending bit 1 set; W1C write PENDING=0x02 on the same edge as a new rising edge on SRC_I[1] -> PENDING reads 0x02 (set wins).
- Assert RST_I=0 while in SERVICE with pending 0x07 -> IRQ=0, all registers 0 immediately. After release, no IRQ until new source activity.
